// File: rtl/hazard_pkg.sv
// Shared types and defaults for the scoreboard hazard unit.
// Optional feature macro: HAZARD_FWD_EN (forwarding-aware hazard rules).
package hazard_pkg;

    localparam int unsigned DEF_REG_W      = 3;
    localparam int unsigned DEF_NUM_SRC    = 2;
    localparam int unsigned DEF_PIPE_DEPTH = 3;
    localparam int unsigned DEF_CNT_W      = 16;

    // Widest register address the scoreboard entry can hold; REG_W must not exceed it.
    localparam int unsigned SB_DST_W = 8;

    typedef struct packed {
        logic                valid;
        logic [SB_DST_W-1:0] dst;
        logic                load;
    } sb_entry_t;

    // Actions in priority order, highest first.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_STALL,
        ACT_RUN
    } action_t;

endpackage

// File: rtl/hazard_match.sv
// Compares every valid ID source operand against one scoreboard entry.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W   = DEF_REG_W,
    parameter int unsigned NUM_SRC = DEF_NUM_SRC
) (
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_vld,
    input  logic                     ent_valid,
    input  logic [REG_W-1:0]         ent_dst,
    output logic                     match
);

    // Any read source naming the entry's destination register is a match.
    always_comb begin
        match = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (id_src_vld[k] && (id_src[k*REG_W +: REG_W] == ent_dst)) begin
                match = 1'b1;
            end
        end
        match = match & id_valid & ent_valid;
    end

endmodule

// File: rtl/hazard_sb.sv
// Scoreboard hazard unit: tracks in-flight register writes EX..WB and drives
// PC / IF/ID / ID/EX / back-end enables. Define HAZARD_FWD_EN when a forwarding
// network exists; otherwise any in-flight producer before WB stalls the reader.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W      = DEF_REG_W,
    parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
    parameter int unsigned PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_vld,
    input  logic                     id_early,
    input  logic                     id_wr,
    input  logic [REG_W-1:0]         id_dst,
    input  logic                     id_load,
    input  logic                     branch_taken,
    input  logic                     mem_busy,
    output logic                     pc_write,
    output logic                     ifid_write,
    output logic                     ifid_flush,
    output logic                     idex_bubble,
    output logic                     pipe_en,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [PIPE_DEPTH-1:0]    sb_valid
);

    sb_entry_t [PIPE_DEPTH-1:0] sb;
    logic [PIPE_DEPTH-2:0]      match_vec;
    logic                       hazard;
    action_t                    act;
    sb_entry_t                  new_ent;

    // The WB entry is never compared: the regfile writes before it reads.
    for (genvar i = 0; i < PIPE_DEPTH - 1; i++) begin : g_match
        hazard_match #(
            .REG_W   (REG_W),
            .NUM_SRC (NUM_SRC)
        ) u_match (
            .id_valid   (id_valid),
            .id_src     (id_src),
            .id_src_vld (id_src_vld),
            .ent_valid  (sb[i].valid),
            .ent_dst    (sb[i].dst[REG_W-1:0]),
            .match      (match_vec[i])
        );
    end

    // Hazard decision from the per-entry matches.
    always_comb begin
`ifdef HAZARD_FWD_EN
        hazard = (match_vec[0] & sb[0].load) | (id_early & (|match_vec));
`else
        hazard = |match_vec;
`endif
    end

`ifndef HAZARD_FWD_EN
    logic unused_early;
    assign unused_early = id_early;
`endif

    // Not every entry field is consumed (WB dst/load, high dst bits).
    logic unused_sb;
    assign unused_sb = ^sb;

    // Priority-encode the action for this cycle.
    always_comb begin
        if (rst)               act = ACT_RESET;
        else if (mem_busy)     act = ACT_FREEZE;
        else if (branch_taken) act = ACT_FLUSH;
        else if (hazard)       act = ACT_STALL;
        else                   act = ACT_RUN;
    end

    // Enables and bubble controls for the chosen action.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b0;
        unique case (act)
            ACT_RESET: begin
                idex_bubble = 1'b1;
            end
            ACT_FREEZE: begin
            end
            ACT_FLUSH: begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                pipe_en     = 1'b1;
            end
            ACT_STALL: begin
                idex_bubble = 1'b1;
                pipe_en     = 1'b1;
            end
            ACT_RUN: begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                pipe_en     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Entry presented by the ID instruction when it advances into EX.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = id_valid & id_wr;
        new_ent.dst   = SB_DST_W'(id_dst);
        new_ent.load  = id_load;
    end

    // Scoreboard shift and saturating stall counter.
    always_ff @(posedge clk) begin
        unique case (act)
            ACT_RESET: begin
                sb        <= '0;
                stall_cnt <= '0;
            end
            ACT_FREEZE: begin
            end
            ACT_FLUSH, ACT_STALL: begin
                for (int unsigned i = PIPE_DEPTH - 1; i > 0; i--) begin
                    sb[i] <= sb[i-1];
                end
                sb[0] <= '0;
                if (act == ACT_STALL && stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end
            ACT_RUN: begin
                for (int unsigned i = PIPE_DEPTH - 1; i > 0; i--) begin
                    sb[i] <= sb[i-1];
                end
                sb[0] <= new_ent;
            end
            default: begin
            end
        endcase
    end

    // Debug view of entry valid bits.
    always_comb begin
        sb_valid = '0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            sb_valid[i] = sb[i].valid;
        end
    end

endmodule
